// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB widths, source ids and the round-robin pick helper.
package cdb_arbiter_pkg;

  localparam int TAG_W     = 4;
  localparam int DATA_W    = 32;
  localparam int CDB_SRC_W = 2;

  localparam logic [CDB_SRC_W-1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [CDB_SRC_W-1:0] CDB_SRC_LS  = 2'd1;
  localparam logic [CDB_SRC_W-1:0] CDB_SRC_BR  = 2'd2;

  typedef struct packed {
    logic                 vld;
    logic [CDB_SRC_W-1:0] src;
  } cdb_grant_t;

  // First requester at or after ptr in ALU->LS->BR order; ptr==3 behaves as ALU.
  function automatic cdb_grant_t rr_pick(input logic [2:0] req,
                                         input logic [CDB_SRC_W-1:0] ptr);
    cdb_grant_t g;
    int start;
    int idx;
    g     = '0;
    start = (ptr == 2'd3) ? 0 : int'(ptr);
    // Walk farthest-first so the nearest requester is the one left standing.
    for (int k = 2; k >= 0; k--) begin
      idx = start + k;
      if (idx >= 3) idx = idx - 3;
      if (req[idx]) begin
        g.vld = 1'b1;
        g.src = CDB_SRC_W'(idx);
      end
    end
    return g;
  endfunction

  function automatic logic [CDB_SRC_W-1:0] rr_next(input logic [CDB_SRC_W-1:0] src);
    return (src == CDB_SRC_BR) ? CDB_SRC_ALU : src + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Small per-producer result queue; full/empty derived only from the entry count.
module cdb_src_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointers/count; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; flush and reset drop the incoming entry.
  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Three producer queues feeding a round-robin arbiter and a registered CDB broadcast.
module cdb_arbiter #(
  parameter int TAG_W   = cdb_arbiter_pkg::TAG_W,
  parameter int DATA_W  = cdb_arbiter_pkg::DATA_W,
  parameter int Q_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             alu_valid,
  output logic                             alu_ready,
  input  logic [TAG_W-1:0]                 alu_tag,
  input  logic [DATA_W-1:0]                alu_data,
  input  logic                             ls_valid,
  output logic                             ls_ready,
  input  logic [TAG_W-1:0]                 ls_tag,
  input  logic [DATA_W-1:0]                ls_data,
  input  logic                             br_valid,
  output logic                             br_ready,
  input  logic [TAG_W-1:0]                 br_tag,
  input  logic [DATA_W-1:0]                br_data,
  output logic                             cdb_valid,
  output logic [cdb_arbiter_pkg::CDB_SRC_W-1:0] cdb_src,
  output logic [TAG_W-1:0]                 cdb_tag,
  output logic [DATA_W-1:0]                cdb_data
);

  import cdb_arbiter_pkg::*;

  localparam int W = TAG_W + DATA_W;

  logic [2:0]           push, pop, full, empty;
  logic [W-1:0]         din  [3];
  logic [W-1:0]         dout [3];
  logic [W-1:0]         sel;
  cdb_grant_t           grant;
  logic [CDB_SRC_W-1:0] rr_q, rr_d, src_q, src_d;
  logic                 valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [DATA_W-1:0]    data_q, data_d;

  assign din[0] = {alu_tag, alu_data};
  assign din[1] = {ls_tag, ls_data};
  assign din[2] = {br_tag, br_data};
  assign push   = {br_valid, ls_valid, alu_valid};

  for (genvar i = 0; i < 3; i++) begin : g_q
    cdb_src_fifo #(.W(W), .DEPTH(Q_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .din   (din[i]),
      .full  (full[i]),
      .pop   (pop[i]),
      .dout  (dout[i]),
      .empty (empty[i])
    );
  end

  assign alu_ready = ~full[0];
  assign ls_ready  = ~full[1];
  assign br_ready  = ~full[2];

  // Pick a winner from current queue heads; flush suppresses the pop and the broadcast.
  always_comb begin
    grant   = rr_pick(~empty, rr_q);
    pop     = '0;
    rr_d    = rr_q;
    valid_d = 1'b0;
    src_d   = src_q;
    tag_d   = tag_q;
    data_d  = data_q;
    case (grant.src)
      CDB_SRC_LS: sel = dout[1];
      CDB_SRC_BR: sel = dout[2];
      default:    sel = dout[0];
    endcase
    if (grant.vld && !flush) begin
      pop             = 3'b001 << grant.src;
      rr_d            = rr_next(grant.src);
      valid_d         = 1'b1;
      src_d           = grant.src;
      {tag_d, data_d} = sel;
    end
  end

  // Round-robin pointer and broadcast registers; payload holds when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q    <= CDB_SRC_ALU;
      valid_q <= 1'b0;
      src_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_src   = src_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench: accepted pushes are queued per source, a negedge monitor checks each broadcast.
module tb_cdb_arbiter;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int W      = TAG_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              alu_valid, ls_valid, br_valid;
  logic              alu_ready, ls_ready, br_ready;
  logic [TAG_W-1:0]  alu_tag, ls_tag, br_tag;
  logic [DATA_W-1:0] alu_data, ls_data, br_data;
  logic              cdb_valid;
  logic [1:0]        cdb_src;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .Q_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_tag(alu_tag), .alu_data(alu_data),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_tag(ls_tag), .ls_data(ls_data),
    .br_valid(br_valid), .br_ready(br_ready), .br_tag(br_tag), .br_data(br_data),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q_alu[$], q_ls[$], q_br[$];
  int           ord_q[$];
  int           br_wait = 0;

  function automatic void chk(input bit ok, input string nm,
                              input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: every broadcast must match the head of its source queue (and order, when given).
  always @(negedge clk) begin
    logic [W-1:0] e;
    bit           have;
    bit           br_pend;
    int           o;
    br_pend = (q_br.size() > 0);
    if (cdb_valid) begin
      have = 1'b0;
      e    = '0;
      case (cdb_src)
        2'd0: if (q_alu.size() > 0) begin e = q_alu.pop_front(); have = 1'b1; end
        2'd1: if (q_ls.size()  > 0) begin e = q_ls.pop_front();  have = 1'b1; end
        2'd2: if (q_br.size()  > 0) begin e = q_br.pop_front();  have = 1'b1; end
        default: have = 1'b0;
      endcase
      if (!have) chk(1'b0, "unexpected_bcast", {cdb_src, cdb_tag, cdb_data}, 64'h0);
      else       chk({cdb_tag, cdb_data} == e, "bcast_payload", {cdb_tag, cdb_data}, e);
      if (ord_q.size() > 0) begin
        o = ord_q.pop_front();
        chk(cdb_src == 2'(o), "bcast_order", cdb_src, o);
      end
      if (cdb_src == 2'd2) begin
        chk(br_wait <= 3, "br_fairness_wait", br_wait, 3);
        br_wait = 0;
      end else if (br_pend) br_wait++;
    end else if (br_pend) br_wait++;
    if (q_br.size() == 0) br_wait = 0;
  end

  // Drive settles, then log accepted handshakes for the coming edge and advance one cycle.
  task automatic tick();
    #1;
    if (!rst || flush) begin
      q_alu.delete(); q_ls.delete(); q_br.delete(); ord_q.delete();
    end else begin
      if (alu_valid && alu_ready) q_alu.push_back({alu_tag, alu_data});
      if (ls_valid  && ls_ready)  q_ls.push_back({ls_tag, ls_data});
      if (br_valid  && br_ready)  q_br.push_back({br_tag, br_data});
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; ls_valid = 0; br_valid = 0; flush = 0;
  endtask

  task automatic push3(input logic [TAG_W-1:0] ta, tl, tb);
    alu_valid = 1; alu_tag = ta; alu_data = 32'hA000 + 32'(ta);
    ls_valid  = 1; ls_tag  = tl; ls_data  = 32'hB000 + 32'(tl);
    br_valid  = 1; br_tag  = tb; br_data  = 32'hC000 + 32'(tb);
  endtask

  // After a same-cycle push on all sources: three back-to-back broadcasts, then idle.
  task automatic expect_burst3(input string nm);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(cdb_valid == 1'b1, nm, cdb_valid, 1);
    end
    tick();
    chk(cdb_valid == 1'b0, {nm, "_end"}, cdb_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bi;
    bit  acc, saw_low;
    logic [TAG_W-1:0] br_tags [4];

    rst = 0; idle_inputs();
    alu_tag = 0; ls_tag = 0; br_tag = 0; alu_data = 0; ls_data = 0; br_data = 0;
    @(negedge clk);

    // Reset with all producers offering: nothing may be queued.
    push3(4'h7, 4'h8, 4'h9);
    tick(); tick();
    chk({cdb_valid, cdb_src, cdb_tag, cdb_data} == '0, "reset_cdb", {cdb_valid, cdb_src, cdb_tag}, 0);
    chk({alu_ready, ls_ready, br_ready} == 3'b111, "reset_ready", {alu_ready, ls_ready, br_ready}, 3'b111);
    rst = 1; idle_inputs();
    tick(); tick(); tick();
    chk(cdb_valid == 1'b0, "post_reset_idle", cdb_valid, 0);
    chk({alu_ready, ls_ready, br_ready} == 3'b111, "post_reset_ready", {alu_ready, ls_ready, br_ready}, 3'b111);

    // Single ALU result: visible two edges after the push, for one cycle only.
    alu_valid = 1; alu_tag = 4'd5; alu_data = 32'h1234;
    ord_q.push_back(0);
    tick();
    idle_inputs();
    chk(cdb_valid == 1'b0, "single_no_bypass", cdb_valid, 0);
    tick();
    chk(cdb_valid == 1'b1, "single_valid", cdb_valid, 1);
    chk(cdb_src == 2'd0, "single_src", cdb_src, 0);
    tick();
    chk(cdb_valid == 1'b0, "single_one_cycle", cdb_valid, 0);
    chk(cdb_tag == 4'd5 && cdb_data == 32'h1234, "single_hold", {cdb_tag, cdb_data}, {4'd5, 32'h1234});

    // Contention from pointer at ALU: ALU, LS, BR.
    rst = 0; tick(); rst = 1;
    push3(4'd1, 4'd2, 4'd3);
    ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(2);
    expect_burst3("contend_alu_first");

    // Move pointer to LS with a lone ALU grant, then contend: LS, BR, ALU.
    alu_valid = 1; alu_tag = 4'd4; alu_data = 32'h44;
    ord_q.push_back(0);
    tick(); idle_inputs(); tick(); tick();
    push3(4'd6, 4'd7, 4'd8);
    ord_q.push_back(1); ord_q.push_back(2); ord_q.push_back(0);
    expect_burst3("contend_ls_first");

    // Backpressure: ALU/LS saturate while BR offers four tags in turn.
    br_tags[0] = 4'd9; br_tags[1] = 4'd10; br_tags[2] = 4'd11; br_tags[3] = 4'd12;
    bi = 0; saw_low = 0;
    for (int c = 0; c < 40; c++) begin
      alu_valid = (c < 20); alu_tag = 4'(c); alu_data = 32'h100 + 32'(c);
      ls_valid  = (c < 20); ls_tag  = 4'(c); ls_data  = 32'h200 + 32'(c);
      br_valid  = (bi < 4);
      br_tag    = br_tags[bi % 4]; br_data = 32'h300 + 32'(bi);
      if (!br_ready) saw_low = 1;
      acc = br_valid && br_ready;
      tick();
      if (acc) bi++;
    end
    idle_inputs();
    chk(bi == 4, "bp_all_br_accepted", bi, 4);
    chk(saw_low == 1'b1, "bp_br_ready_dropped", saw_low, 1);
    tick(); tick();
    chk(q_alu.size() + q_ls.size() + q_br.size() == 0, "bp_drained",
        q_alu.size() + q_ls.size() + q_br.size(), 0);

    // Flush with queued entries and a same-cycle LS push: none of it may appear.
    push3(4'd1, 4'd2, 4'd3); tick();
    push3(4'd4, 4'd5, 4'd6); tick();
    idle_inputs();
    flush = 1; ls_valid = 1; ls_tag = 4'hE; ls_data = 32'hDEAD;
    tick();
    idle_inputs();
    chk(cdb_valid == 1'b0, "flush_next_idle", cdb_valid, 0);
    for (int i = 0; i < 6; i++) tick();
    chk(cdb_valid == 1'b0, "flush_stays_idle", cdb_valid, 0);

    // Reset while the bus is busy; pointer returns to ALU.
    for (int c = 0; c < 4; c++) begin
      push3(4'(c), 4'(c + 4), 4'(c + 8));
      tick();
    end
    chk(cdb_valid == 1'b1, "midstream_busy", cdb_valid, 1);
    rst = 0;
    tick();
    chk(cdb_valid == 1'b0, "midstream_reset_idle", cdb_valid, 0);
    rst = 1;
    push3(4'd13, 4'd14, 4'd15);
    ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(2);
    expect_burst3("midstream_ptr_alu");

    for (int i = 0; i < 4; i++) tick();
    chk(q_alu.size() + q_ls.size() + q_br.size() == 0, "final_drained",
        q_alu.size() + q_ls.size() + q_br.size(), 0);
    chk(ord_q.size() == 0, "final_order_consumed", ord_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
